// File: rtl/board_ctrl.sv
// Tic-tac-toe game-state controller: holds the board, alternates player/CPU turns, validates moves, detects win/draw.
// Optional CPU move fallback after CPU_TIMEOUT cycles when BOARD_CPU_TIMEOUT_EN is defined.
module board_ctrl #(
  parameter int CPU_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        new_game,
  input  logic        move_valid,
  input  logic [3:0]  move_coord,
  output logic        cpu_req,
  input  logic        cpu_valid,
  input  logic [3:0]  cpu_coord,
  output logic [17:0] board,
  output logic [8:0]  occupied,
  output logic        illegal,
  output logic        game_over,
  output logic [1:0]  winner
);

  typedef enum logic [2:0] {S_PLAYER, S_EVAL_P, S_CPU_WAIT, S_EVAL_C, S_OVER} state_t;

  state_t      state, state_n;
  logic [17:0] board_n;
  logic        illegal_n;
  logic [1:0]  winner_n;
  logic [15:0] occ_pad;
  logic        move_legal, cpu_legal;

  function automatic logic has_line(input logic [17:0] b, input logic [1:0] who);
    logic [8:0] m;
    for (int i = 0; i < 9; i++) m[i] = (b[2*i +: 2] == who);
    return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
           (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
           (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
  endfunction

  function automatic logic [17:0] put(input logic [17:0] b, input logic [3:0] idx,
                                      input logic [1:0] who);
    logic [17:0] r;
    r = b;
    for (int i = 0; i < 9; i++)
      if (idx == 4'(i)) r[2*i +: 2] = who;
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < 9; i++) occupied[i] = |board[2*i +: 2];
  end

  // Indices 9..15 read as occupied so one lookup covers both range and emptiness.
  assign occ_pad    = {7'h7f, occupied};
  assign move_legal = !occ_pad[move_coord];
  assign cpu_legal  = !occ_pad[cpu_coord];
  assign cpu_req    = (state == S_CPU_WAIT);
  assign game_over  = (state == S_OVER);

`ifdef BOARD_CPU_TIMEOUT_EN
  localparam int CW = (CPU_TIMEOUT > 2) ? $clog2(CPU_TIMEOUT) : 1;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    first_empty;
  logic          timeout_hit;

  always_comb begin
    first_empty = 4'd0;
    for (int i = 8; i >= 0; i--)
      if (!occupied[i]) first_empty = 4'(i);
  end

  assign timeout_hit = (cnt == CW'(CPU_TIMEOUT - 1));
  assign cnt_n       = (state == S_CPU_WAIT) ? cnt + 1'b1 : '0;

  always_ff @(posedge clock) begin
    if (!reset) cnt <= '0;
    else        cnt <= cnt_n;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^CPU_TIMEOUT;
`endif

  always_comb begin
    state_n   = state;
    board_n   = board;
    illegal_n = 1'b0;
    winner_n  = winner;
    if (new_game) begin
      state_n  = S_PLAYER;
      board_n  = '0;
      winner_n = 2'b00;
    end else begin
      case (state)
        S_PLAYER: begin
          if (move_valid) begin
            if (move_legal) begin
              board_n = put(board, move_coord, 2'b01);
              state_n = S_EVAL_P;
            end else begin
              illegal_n = 1'b1;
            end
          end
        end
        S_EVAL_P: begin
          if (has_line(board, 2'b01)) begin
            state_n  = S_OVER;
            winner_n = 2'b01;
          end else if (&occupied) begin
            state_n  = S_OVER;
            winner_n = 2'b00;
          end else begin
            state_n = S_CPU_WAIT;
          end
        end
        S_CPU_WAIT: begin
          if (cpu_valid && cpu_legal) begin
            board_n = put(board, cpu_coord, 2'b10);
            state_n = S_EVAL_C;
          end else begin
            if (cpu_valid) illegal_n = 1'b1;
`ifdef BOARD_CPU_TIMEOUT_EN
            if (timeout_hit) begin
              board_n = put(board, first_empty, 2'b10);
              state_n = S_EVAL_C;
            end
`endif
          end
        end
        S_EVAL_C: begin
          if (has_line(board, 2'b10)) begin
            state_n  = S_OVER;
            winner_n = 2'b10;
          end else if (&occupied) begin
            state_n  = S_OVER;
            winner_n = 2'b00;
          end else begin
            state_n = S_PLAYER;
          end
        end
        S_OVER:  ;
        default: state_n = S_PLAYER;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= S_PLAYER;
      board   <= '0;
      illegal <= 1'b0;
      winner  <= 2'b00;
    end else begin
      state   <= state_n;
      board   <= board_n;
      illegal <= illegal_n;
      winner  <= winner_n;
    end
  end

endmodule

// File: tb/tb_board_ctrl.sv
// Directed bench for board_ctrl: reset, turn flow, illegal moves, win, draw, new_game priority, CPU fallback.
module tb_board_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic        new_game, move_valid, cpu_valid;
  logic [3:0]  move_coord, cpu_coord;
  logic        cpu_req, illegal, game_over;
  logic [17:0] board;
  logic [8:0]  occupied;
  logic [1:0]  winner;
  int checks = 0;
  int failures = 0;

  board_ctrl #(.CPU_TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .new_game(new_game),
    .move_valid(move_valid), .move_coord(move_coord),
    .cpu_req(cpu_req), .cpu_valid(cpu_valid), .cpu_coord(cpu_coord),
    .board(board), .occupied(occupied), .illegal(illegal),
    .game_over(game_over), .winner(winner)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change just after a falling edge and are sampled by the next rising edge.
  task automatic player(input logic [3:0] c);
    move_valid = 1'b1; move_coord = c; tick(); move_valid = 1'b0;
  endtask

  task automatic cpu(input logic [3:0] c);
    cpu_valid = 1'b1; cpu_coord = c; tick(); cpu_valid = 1'b0;
  endtask

  task automatic restart();
    new_game = 1'b1; tick(); new_game = 1'b0;
  endtask

  initial begin
    reset = 1'b0; new_game = 1'b0; move_valid = 1'b0; cpu_valid = 1'b0;
    move_coord = 4'd0; cpu_coord = 4'd0;
    tick(); tick();
    chk("rst_board", 32'(board), 32'h0);
    chk("rst_occupied", 32'(occupied), 32'h0);
    chk("rst_cpu_req", 32'(cpu_req), 32'h0);
    chk("rst_illegal", 32'(illegal), 32'h0);
    chk("rst_game_over", 32'(game_over), 32'h0);
    chk("rst_winner", 32'(winner), 32'h0);
    reset = 1'b1; tick();

    // first move latency
    player(4'd4);
    chk("mv4_board", 32'(board), 32'h00100);
    chk("mv4_cpu_req_eval", 32'(cpu_req), 32'h0);
    tick();
    chk("mv4_cpu_req", 32'(cpu_req), 32'h1);
    chk("mv4_occupied", 32'(occupied), 32'h010);

    // illegal CPU move onto an occupied cell
    cpu(4'd4);
    chk("cpu_ill_pulse", 32'(illegal), 32'h1);
    chk("cpu_ill_req", 32'(cpu_req), 32'h1);
    chk("cpu_ill_board", 32'(board), 32'h00100);
    tick();
    chk("cpu_ill_clear", 32'(illegal), 32'h0);

    // new_game beats a simultaneous CPU move
    new_game = 1'b1; cpu_valid = 1'b1; cpu_coord = 4'd0; tick();
    new_game = 1'b0; cpu_valid = 1'b0;
    chk("ng_board", 32'(board), 32'h0);
    chk("ng_cpu_req", 32'(cpu_req), 32'h0);
    tick();
    chk("ng_board_hold", 32'(board), 32'h0);
    chk("ng_illegal", 32'(illegal), 32'h0);

    // player wins on the top row
    player(4'd0); tick(); cpu(4'd3); tick();
    player(4'd1); tick(); cpu(4'd4); tick();
    player(4'd2);
    chk("win_eval_go", 32'(game_over), 32'h0);
    tick();
    chk("win_game_over", 32'(game_over), 32'h1);
    chk("win_winner", 32'(winner), 32'h1);
    chk("win_cpu_req", 32'(cpu_req), 32'h0);
    chk("win_board", 32'(board), 32'h00295);
    player(4'd5);
    chk("over_mv_illegal", 32'(illegal), 32'h0);
    cpu(4'd6);
    chk("over_cpu_illegal", 32'(illegal), 32'h0);
    tick();
    chk("over_board", 32'(board), 32'h00295);
    chk("over_cpu_req", 32'(cpu_req), 32'h0);
    chk("over_hold", 32'(game_over), 32'h1);
    restart();
    chk("ng2_game_over", 32'(game_over), 32'h0);
    chk("ng2_winner", 32'(winner), 32'h0);
    chk("ng2_board", 32'(board), 32'h0);

    // illegal player moves: occupied cell, then out of range
    player(4'd4); tick(); cpu(4'd0); tick();
    player(4'd4);
    chk("p_occ_pulse", 32'(illegal), 32'h1);
    chk("p_occ_board", 32'(board), 32'h00102);
    tick();
    chk("p_occ_clear", 32'(illegal), 32'h0);
    chk("p_occ_req", 32'(cpu_req), 32'h0);
    player(4'd9);
    chk("p_9_pulse", 32'(illegal), 32'h1);
    chk("p_9_board", 32'(board), 32'h00102);
    tick();
    chk("p_9_clear", 32'(illegal), 32'h0);
    player(4'd8); tick();
    chk("p_still_player", 32'(cpu_req), 32'h1);
    player(4'd1);
    chk("p_wait_ignored_ill", 32'(illegal), 32'h0);
    chk("p_wait_ignored_board", 32'(board), 32'h10102);
    restart();

    // full board, no line
    player(4'd0); tick(); cpu(4'd1); tick();
    player(4'd2); tick(); cpu(4'd4); tick();
    player(4'd3); tick(); cpu(4'd5); tick();
    player(4'd7); tick(); cpu(4'd6); tick();
    player(4'd8); tick();
    chk("draw_game_over", 32'(game_over), 32'h1);
    chk("draw_winner", 32'(winner), 32'h0);
    chk("draw_board", 32'(board), 32'h16a59);
    chk("draw_occupied", 32'(occupied), 32'h1ff);
    chk("draw_cpu_req", 32'(cpu_req), 32'h0);
    restart();

    player(4'd0); tick();
`ifdef BOARD_CPU_TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick();
    chk("to_before_req", 32'(cpu_req), 32'h1);
    chk("to_before_board", 32'(board), 32'h00001);
    tick();
    chk("to_fire_board", 32'(board), 32'h00009);
    chk("to_fire_req", 32'(cpu_req), 32'h0);
    tick();
    chk("to_back_player", 32'(cpu_req), 32'h0);
`else
    for (int i = 0; i < 300; i++) tick();
    chk("nto_req", 32'(cpu_req), 32'h1);
    chk("nto_board", 32'(board), 32'h00001);
`endif

    // reset mid-game drops a pending CPU move
    reset = 1'b0; cpu_valid = 1'b1; cpu_coord = 4'd2; tick();
    reset = 1'b1; cpu_valid = 1'b0;
    chk("mid_rst_board", 32'(board), 32'h0);
    chk("mid_rst_req", 32'(cpu_req), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
